// File: rtl/control_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Opcode offsets, funct codes, control encodings, control-word
//                field positions and FSM states for the control pipe.
//  Revision    : 1.0  initial release
// ============================================================================
package control_pkg;

    localparam int c_op_r_ofs  = 0;
    localparam int c_op_lw_ofs = 1;
    localparam int c_op_sw_ofs = 2;

    localparam logic [5:0] c_fn_add = 6'd32;
    localparam logic [5:0] c_fn_sub = 6'd34;
    localparam logic [5:0] c_fn_and = 6'd36;
    localparam logic [5:0] c_fn_or  = 6'd37;
    localparam logic [5:0] c_fn_mul = 6'd50;

    localparam logic [16:0] c_ctrl_add = 17'h00400;
    localparam logic [16:0] c_ctrl_sub = 17'h02400;
    localparam logic [16:0] c_ctrl_and = 17'h04400;
    localparam logic [16:0] c_ctrl_or  = 17'h06400;
    localparam logic [16:0] c_ctrl_mul = 17'h00600;
    localparam logic [16:0] c_ctrl_lw  = 17'h10C00;
    localparam logic [16:0] c_ctrl_sw  = 17'h11800;

    localparam int c_rs_lsb = 27;
    localparam int c_rt_lsb = 22;
    localparam int c_rd_lsb = 17;

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    function automatic logic [31:0] pack_word(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [16:0] ctrl);
        return (32'(rs) << c_rs_lsb) | (32'(rt) << c_rt_lsb) |
               (32'(rd) << c_rd_lsb) | 32'(ctrl);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipe_if
//  Description : Instruction-in / control-word-out handshake bundle plus flush.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_pipe_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] control_out;

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, control_out
    );

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, control_out
    );
endinterface
`default_nettype wire

// File: rtl/control_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : control_decode
//  Description : Combinational instruction decoder: control word plus the
//                source-use and load-destination flags needed for hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module control_decode
    import control_pkg::*;
#(
    parameter int GROUP = 9
) (
    input  wire logic [31:0] i_instruction,
    output logic      [31:0] o_word,
    output logic      [4:0]  o_rs,
    output logic      [4:0]  o_rt,
    output logic      [4:0]  o_dest,
    output logic             o_uses_rs,
    output logic             o_uses_rt,
    output logic             o_is_lw
);

    localparam logic [5:0] c_op_r  = 6'(GROUP + c_op_r_ofs);
    localparam logic [5:0] c_op_lw = 6'(GROUP + c_op_lw_ofs);
    localparam logic [5:0] c_op_sw = 6'(GROUP + c_op_sw_ofs);

    logic [5:0] w_op;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic       w_unused_bits;

    assign w_op          = i_instruction[31:26];
    assign o_rs          = i_instruction[25:21];
    assign o_rt          = i_instruction[20:16];
    assign w_rd          = i_instruction[15:11];
    assign w_funct       = i_instruction[5:0];
    assign w_unused_bits = ^i_instruction[10:6];

    always_comb begin
        o_word    = '0;
        o_dest    = '0;
        o_uses_rs = 1'b0;
        o_uses_rt = 1'b0;
        o_is_lw   = 1'b0;
        if (w_op == c_op_r) begin
            o_uses_rs = 1'b1;
            o_uses_rt = 1'b1;
            case (w_funct)
                c_fn_add: o_word = pack_word(o_rs, o_rt, w_rd, c_ctrl_add);
                c_fn_sub: o_word = pack_word(o_rs, o_rt, w_rd, c_ctrl_sub);
                c_fn_and: o_word = pack_word(o_rs, o_rt, w_rd, c_ctrl_and);
                c_fn_or:  o_word = pack_word(o_rs, o_rt, w_rd, c_ctrl_or);
                c_fn_mul: o_word = pack_word(o_rs, o_rt, w_rd, c_ctrl_mul);
                default:  o_word = '0;
            endcase
        end else if (w_op == c_op_lw) begin
            // Load destination lives in the rt field and is moved to rd.
            o_uses_rs = 1'b1;
            o_is_lw   = 1'b1;
            o_dest    = o_rt;
            o_word    = pack_word(o_rs, 5'd0, o_rt, c_ctrl_lw);
        end else if (w_op == c_op_sw) begin
            o_uses_rs = 1'b1;
            o_uses_rt = 1'b1;
            o_word    = pack_word(o_rs, o_rt, 5'd0, c_ctrl_sw);
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipe
//  Description : Registered instruction decoder with valid/ready output and
//                load-use bubble insertion. Optional perf counters are built
//                when CONTROL_PIPE_PERF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module control_pipe
    import control_pkg::*;
#(
    parameter int GROUP            = 9,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    control_pipe_if.slave    bus
`ifdef CONTROL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_instr_cnt,
    output logic [CNT_W-1:0] perf_bubble_cnt
`endif
);

    localparam logic       c_detect_on = (LOAD_USE_BUBBLES > 0);
    localparam logic [1:0] c_cnt_init  = 2'(LOAD_USE_BUBBLES - 1);

    logic [31:0] w_dec_word;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_dest;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_is_lw;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_out_valid;
    logic [31:0] r_control_out;
    logic [4:0]  r_tag;
    logic        r_tag_vld;

    logic        w_free;
    logic        w_hazard;
    logic        w_accept;
    logic        w_bubble;

    control_decode #(.GROUP(GROUP)) u_decode (
        .i_instruction (bus.instruction),
        .o_word        (w_dec_word),
        .o_rs          (w_rs),
        .o_rt          (w_rt),
        .o_dest        (w_dest),
        .o_uses_rs     (w_uses_rs),
        .o_uses_rt     (w_uses_rt),
        .o_is_lw       (w_is_lw)
    );

    // The tag is only ever armed with a non-zero register, so r0 never matches.
    assign w_free   = !r_out_valid || bus.out_ready;
    assign w_hazard = c_detect_on && r_tag_vld && bus.in_valid &&
                      ((w_uses_rs && (w_rs == r_tag)) || (w_uses_rt && (w_rt == r_tag)));
    assign bus.in_ready    = w_free && (r_state == ST_PASS) && !w_hazard;
    assign w_accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.control_out = r_control_out;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bubble    = 1'b0;
        case (r_state)
            ST_PASS: begin
                if (w_free && w_hazard) begin
                    w_bubble  = 1'b1;
                    w_cnt_nxt = c_cnt_init;
                    if (c_cnt_init != 2'd0) w_state_nxt = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                if (w_free) begin
                    w_bubble  = 1'b1;
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) w_state_nxt = ST_PASS;
                end
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_state       <= ST_PASS;
            r_cnt         <= 2'd0;
            r_out_valid   <= 1'b0;
            r_control_out <= '0;
            r_tag         <= '0;
            r_tag_vld     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_free) begin
                r_out_valid <= w_accept || w_bubble;
                if (w_bubble)      r_control_out <= '0;
                else if (w_accept) r_control_out <= w_dec_word;
            end
            if (w_bubble) begin
                r_tag_vld <= 1'b0;
            end else if (w_accept) begin
                r_tag_vld <= w_is_lw && (w_dest != 5'd0);
                r_tag     <= w_dest;
            end
        end
    end

`ifdef CONTROL_PIPE_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (w_accept && !bus.flush) perf_instr_cnt  <= perf_instr_cnt + 1'b1;
            if (w_bubble && !bus.flush) perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
        end
    end
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_pipe
//  Description : Directed, table-driven bench for control_pipe with one-bubble
//                and three-bubble instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_pipe;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    control_pipe_if a_if ();
    control_pipe_if b_if ();

`ifdef CONTROL_PIPE_PERF_EN
    logic [31:0] a_pic, a_pbc, b_pic, b_pbc;
`endif

    control_pipe #(.GROUP(9), .LOAD_USE_BUBBLES(1), .CNT_W(32)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .bus             (a_if)
`ifdef CONTROL_PIPE_PERF_EN
        ,
        .perf_instr_cnt  (a_pic),
        .perf_bubble_cnt (a_pbc)
`endif
    );

    control_pipe #(.GROUP(9), .LOAD_USE_BUBBLES(3), .CNT_W(32)) u_dut3 (
        .clk             (clk),
        .rst             (rst),
        .bus             (b_if)
`ifdef CONTROL_PIPE_PERF_EN
        ,
        .perf_instr_cnt  (b_pic),
        .perf_bubble_cnt (b_pbc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words actually handed to each consumer.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    always @(posedge clk) begin
        if (a_if.out_valid && a_if.out_ready) qa.push_back(a_if.control_out);
        if (b_if.out_valid && b_if.out_ready) qb.push_back(b_if.control_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] LW_R4  = 32'h28240000;
    localparam logic [31:0] LW_EXP = 32'h08090C00;
    localparam logic [31:0] ADD2   = 32'h24822820;
    localparam logic [31:0] ADD2_E = 32'h208A0400;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tab[11];
        logic [31:0] expb[5];

        tab[0]  = '{32'h24221820, 32'h08860400};  // ADD r1,r2 -> r3
        tab[1]  = '{32'h24653822, 32'h194E2400};  // SUB
        tab[2]  = '{32'h24464025, 32'h11906400};  // OR
        tab[3]  = '{32'h254B6032, 32'h52D80600};  // MUL
        tab[4]  = '{32'h24221807, 32'h00000000};  // R-type funct 7
        tab[5]  = '{32'h14221820, 32'h00000000};  // opcode 5
        tab[6]  = '{32'h2C220010, 32'h08811800};  // SW
        tab[7]  = '{32'h28A00004, 32'h28010C00};  // LW into r0
        tab[8]  = '{32'h27E00824, 32'hF8024400};  // AND reads r0: no hazard
        tab[9]  = '{32'h28290000, 32'h08130C00};  // LW into r9
        tab[10] = '{32'h24653822, 32'h194E2400};  // SUB, no r9 use

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_if.flush = 1'b0; a_if.in_valid = 1'b0; a_if.instruction = '0; a_if.out_ready = 1'b1;
        b_if.flush = 1'b0; b_if.in_valid = 1'b0; b_if.instruction = '0; b_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("reset_control_out", a_if.control_out, 32'd0);
        chk("reset_in_ready", 32'(a_if.in_ready), 32'd1);

        // Back-to-back decode, one instruction per cycle.
        for (int i = 0; i < 11; i++) begin
            a_if.in_valid    = 1'b1;
            a_if.instruction = tab[i].instr;
            @(negedge clk);
            chk($sformatf("dec%0d_valid", i), 32'(a_if.out_valid), 32'd1);
            chk($sformatf("dec%0d_word", i), a_if.control_out, tab[i].exp);
        end
        a_if.in_valid = 1'b0;
`ifdef CONTROL_PIPE_PERF_EN
        chk("perf_instr_table", a_pic, 32'd11);
`endif
        @(negedge clk);

        // Load-use with one bubble.
        a_if.in_valid = 1'b1; a_if.instruction = LW_R4;
        @(negedge clk);
        chk("b1_lw_word", a_if.control_out, LW_EXP);
        a_if.instruction = ADD2;
        #1 chk("b1_in_ready_haz", 32'(a_if.in_ready), 32'd0);
        @(negedge clk);
        chk("b1_bubble_valid", 32'(a_if.out_valid), 32'd1);
        chk("b1_bubble_word", a_if.control_out, 32'd0);
        chk("b1_in_ready_after", 32'(a_if.in_ready), 32'd1);
        @(negedge clk);
        chk("b1_add_word", a_if.control_out, ADD2_E);
        a_if.in_valid = 1'b0;
        @(negedge clk);

        // Load-use with three bubbles, consumer stalls mid-bubble.
        qb.delete();
        b_if.in_valid = 1'b1; b_if.instruction = LW_R4;
        @(negedge clk);
        b_if.instruction = ADD2;
        #1 chk("b3_in_ready_haz", 32'(b_if.in_ready), 32'd0);
        @(negedge clk);
        b_if.out_ready = 1'b0;
        @(negedge clk);
        chk("b3_stall_in_ready", 32'(b_if.in_ready), 32'd0);
        @(negedge clk);
        b_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("b3_in_ready_end", 32'(b_if.in_ready), 32'd1);
        @(negedge clk);
        b_if.in_valid = 1'b0;
        @(negedge clk);
        expb[0] = LW_EXP; expb[1] = 32'd0; expb[2] = 32'd0; expb[3] = 32'd0; expb[4] = ADD2_E;
        chk("b3_word_count", 32'(qb.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("b3_word%0d", i), (i < qb.size()) ? qb[i] : 32'hDEADBEEF, expb[i]);
`ifdef CONTROL_PIPE_PERF_EN
        chk("perf_bubble_b3", b_pbc, 32'd3);
        chk("perf_instr_b3", b_pic, 32'd2);
`endif

        // Output stall: word held for four cycles, then released.
        qa.delete();
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.instruction = tab[1].instr;
        @(negedge clk);
        a_if.instruction = tab[2].instr;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stall%0d_word", k), a_if.control_out, tab[1].exp);
            chk($sformatf("stall%0d_in_ready", k), 32'(a_if.in_ready), 32'd0);
            @(negedge clk);
        end
        a_if.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_next_word", a_if.control_out, tab[2].exp);
        a_if.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_count", 32'(qa.size()), 32'd2);
        chk("stall_first", (qa.size() > 0) ? qa[0] : 32'hDEADBEEF, tab[1].exp);

        // Flush drops the held word and beats a simultaneous accept.
        a_if.in_valid = 1'b1; a_if.instruction = tab[0].instr;
        @(negedge clk);
        chk("flush_pre_valid", 32'(a_if.out_valid), 32'd1);
        a_if.flush = 1'b1; a_if.instruction = tab[3].instr;
        @(negedge clk);
        a_if.flush = 1'b0; a_if.in_valid = 1'b0;
        chk("flush_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("flush_control_out", a_if.control_out, 32'd0);
        @(negedge clk);
        chk("flush_dropped", 32'(a_if.out_valid), 32'd0);

        // Flush clears a pending load tag.
        a_if.in_valid = 1'b1; a_if.instruction = LW_R4;
        @(negedge clk);
        a_if.in_valid = 1'b0; a_if.flush = 1'b1;
        @(negedge clk);
        a_if.flush = 1'b0; a_if.in_valid = 1'b1; a_if.instruction = ADD2;
        #1 chk("flush_tag_in_ready", 32'(a_if.in_ready), 32'd1);
        @(negedge clk);
        chk("flush_tag_add", a_if.control_out, ADD2_E);
        a_if.in_valid = 1'b0;

        // Reset in the middle of a bubble run.
        b_if.in_valid = 1'b1; b_if.instruction = LW_R4;
        @(negedge clk);
        b_if.instruction = ADD2;
        @(negedge clk);
        rst = 1'b1; b_if.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        qb.delete();
        chk("rstb_out_valid", 32'(b_if.out_valid), 32'd0);
        chk("rstb_control_out", b_if.control_out, 32'd0);
`ifdef CONTROL_PIPE_PERF_EN
        chk("rstb_perf_bubble", b_pbc, 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("rstb_no_bubbles", 32'(qb.size()), 32'd0);
        b_if.in_valid = 1'b1; b_if.instruction = ADD2;
        #1 chk("rstb_in_ready", 32'(b_if.in_ready), 32'd1);
        @(negedge clk);
        chk("rstb_add_word", b_if.control_out, ADD2_E);
        b_if.in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
